dpb_read_ctrl: RTL

- Consumer-side (reader) controller for a DualPortBuffer instance.
- Owns the read pointer and read enable, and tracks entries committed by the producer (PHY/backend write side).
- Absorbs the buffer's 1-cycle registered-read latency and presents a valid/ready stream to the cache/frontend.
- Returns one free credit per drained entry to the producer. Guarantees the buffer never sees a same-cycle read/write to one address.

---
 rtl/dpb_read_ctrl_pkg.sv | 12 +
 rtl/dpb_read_ctrl_skid_fifo2.sv | 62 ++++++
 rtl/dpb_read_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/dpb_read_ctrl_pkg.sv
// Shared constants and helpers for the DualPortBuffer reader controller and its skid FIFO.
package dpb_read_ctrl_pkg;

  localparam int unsigned SKID_DEPTH     = 2;
  localparam int unsigned MAX_READ_AHEAD = 2;

  // Address width for a buffer of the given depth; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dpb_read_ctrl_skid_fifo2.sv
// Two-entry FIFO with simultaneous push/pop; head is always the oldest stored entry.
module skid_fifo2
  import dpb_read_ctrl_pkg::*;
#(
  parameter type DataEntry = logic,
  localparam int unsigned CntW = $clog2(SKID_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  DataEntry        push_data_i,
  input  logic            pop_i,
  output logic [CntW-1:0] cnt_o,
  output DataEntry        head_o
);

  localparam logic [CntW-1:0] FullCnt = CntW'(SKID_DEPTH);

  DataEntry        mem_q [SKID_DEPTH];
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            pop_ok;
  logic            push_ok;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign pop_ok  = pop_i && (cnt_q != '0);
  assign push_ok = push_i && ((cnt_q != FullCnt) || pop_ok);

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/dpb_read_ctrl.sv
// Reader-side controller for a DualPortBuffer: issues reads for committed entries, hides the
// registered-read latency behind a 2-entry skid and hands one free credit back per drained entry.
module dpb_read_ctrl
  import dpb_read_ctrl_pkg::*;
#(
  parameter int unsigned BufferDepth = 8,
  parameter type DataEntry = logic,
  localparam int unsigned PtrW = ptr_width(BufferDepth),
  localparam int unsigned CntW = $clog2(BufferDepth + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_commit,
  output logic            buf_re,
  output logic [PtrW-1:0] buf_read_ptr,
  input  DataEntry        buf_rdata,
  output logic            buf_free,
  output logic            out_valid,
  input  logic            out_ready,
  output DataEntry        out_data,
  output logic            err_overflow
);

  localparam logic [PtrW-1:0] LastIdx   = PtrW'(BufferDepth - 1);
  localparam logic [CntW-1:0] FullCnt   = CntW'(BufferDepth);
  localparam logic [1:0]      ReadAhead = 2'(MAX_READ_AHEAD);

  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] rd_ptr_d;
  logic [CntW-1:0] pending_q;
  logic [CntW-1:0] pending_d;
  logic            inflight_q;
  logic            err_q;
  logic            err_d;
  logic [1:0]      sk_cnt;
  logic [1:0]      occ;
  logic            pop;
  logic            issue;
  logic            full;

  // Entries already read ahead: parked in the skid plus the one whose data is on buf_rdata.
  assign occ   = sk_cnt + {1'b0, inflight_q};
  assign pop   = out_valid && out_ready;
  assign issue = (pending_q != '0) && ((occ < ReadAhead) || ((occ == ReadAhead) && pop));
  assign full  = (pending_q == FullCnt);

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    pending_d = pending_q;
    err_d     = err_q;
    if (issue) begin
      rd_ptr_d = (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (in_commit && !issue) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        pending_d = pending_q + CntW'(1);
      end
    end else if (!in_commit && issue) begin
      pending_d = pending_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      pending_q  <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      pending_q  <= pending_d;
      inflight_q <= issue;
      err_q      <= err_d;
    end
  end

  skid_fifo2 #(
    .DataEntry(DataEntry)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_i     (inflight_q),
    .push_data_i(buf_rdata),
    .pop_i      (pop),
    .cnt_o      (sk_cnt),
    .head_o     (out_data)
  );

  // The entry's address was read at the previous edge, so the producer may now rewrite it.
  assign buf_free     = inflight_q;
  assign buf_re       = issue;
  assign buf_read_ptr = rd_ptr_q;
  assign out_valid    = (sk_cnt != 2'd0);
  assign err_overflow = err_q;

endmodule
